neuron_cfg_loader: RTL and testbench
====================================

# neuron_cfg_loader

Serial configuration master for a bank of `single_neuron` instances. It accepts one parallel configuration word per valid/ready transaction: a match pattern, an output pattern and a target neuron address. For each word it pulses the selected neuron's reset and then streams the 2*MEMORY-bit word MSB-first on the shared CONTROL line, cycle-aligned to the neuron's write phase. It sits between the chip's host-facing register/IO logic and the neuron array, and is the only driver of neuron RST and CONTROL.

## Interface
Parameters:
- MEMORY, 8: neuron pattern width; must match the neurons' MEMORY.
- NUM_NEURONS, 4: number of neurons driven; must be ≥ 1.
- ADDR_W, $clog2(NUM_NEURONS) (minimum 1): address width.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset, synchronous, active-high.
- CFG_VALID  in  1  request valid.
- CFG_READY  out  1  loader can accept a request.
- CFG_ADDR  in  ADDR_W  target neuron index.
- CFG_BCAST  in  1  program every neuron with the same word; CFG_ADDR is ignored.
- CFG_MATCH  in  MEMORY  pattern the neuron matches on SEQ_IN.
- CFG_OUT  in  MEMORY  pattern the neuron emits on a match.
- NEURON_RST  out  NUM_NEURONS  per-neuron reset, registered.
- NEURON_CONTROL  out  1  shared serial configuration bit, registered.
- LOADED  out  NUM_NEURONS  sticky flag per neuron: programmed since the last RST.
- DONE  out  1  one-cycle pulse when a transaction finishes.
- ERR  out  1  one-cycle pulse, coincident with DONE, for an out-of-range address.

## Operation
- FSM states: IDLE, ARM, SHIFT, FIN.
- IDLE:
  - CFG_READY=1.
  - On CFG_VALID&&CFG_READY: latch the word {CFG_MATCH, CFG_OUT} (MATCH in the upper half), CFG_ADDR and CFG_BCAST, then go to ARM.
- ARM (1 cycle):
  - NEURON_RST is set to one-hot[addr], or all ones if BCAST.
  - If addr ≥ NUM_NEURONS and not BCAST: NEURON_RST=0.
  - Clear the bit counter. Go to SHIFT.
- SHIFT (2*MEMORY cycles):
  - NEURON_RST=0.
  - NEURON_CONTROL = word[2*MEMORY-1-k] on the k-th SHIFT cycle, k=0..2*MEMORY-1.
  - The shift register shifts left by one each cycle.
  - Counter width is $clog2(2*MEMORY). On the last count, go to FIN.
- FIN (1 cycle):
  - DONE=1 and NEURON_CONTROL=0.
  - Set LOADED[addr], or all bits if BCAST.
  - ERR=1 if the address was out of range; LOADED is then unchanged.
  - Go to IDLE.
- CONTROL is shared by all neurons. Neurons sample it only in their write phase, so only the neuron(s) reset in ARM absorb the word.
- CFG_* inputs are ignored outside IDLE. There is no queueing.

## Timing
- Transaction accepted at the edge ending cycle 0.
- Cycle 1: NEURON_RST asserted.
- Cycles 2..2*MEMORY+1: the word bits appear on NEURON_CONTROL.
- Cycle 2*MEMORY+2: DONE.
- Cycle 2*MEMORY+3: IDLE again, CFG_READY=1.
- Period is 2*MEMORY+3 cycles per word (19 for MEMORY=8).
- CFG_READY is registered-state derived: it is 0 from cycle 1 through FIN. Back-to-back requests are accepted on the first IDLE cycle.
- RST=1 behaviour:
  - State goes to IDLE and CFG_READY=0 while RST is high.
  - NEURON_RST=all ones, so neurons are reset with the loader.
  - NEURON_CONTROL=0, LOADED=0, DONE=0, ERR=0.
  - Consequence: after RST the neurons shift in all-zero configuration. This is intended and is reflected by LOADED=0.
- RST mid-SHIFT: the transaction is aborted with no DONE. The word is lost and the neurons are reset as above.
- CFG_VALID held high across FIN: a new transaction starts on the first IDLE cycle. Each accepted word produces exactly one DONE.

## Structure
- Shared package `neuron_pkg`:
  - state enum {IDLE, ARM, SHIFT, FIN}.
  - Function computing the counter width from MEMORY.
  - Constant CFG_WORD_W = 2*MEMORY, used by both loader and neuron.
- Sub-module `cfg_serializer`:
  - Parallel-load, MSB-first PISO of width CFG_WORD_W.
  - Ports: load, shift enable, parallel in, serial out, last-bit flag.
  - The FSM, address decode and LOADED/ERR logic stay in the top module.

## Test plan
- Reset: RST=1 for 3 cycles → NEURON_RST=4'b1111, CONTROL=0, LOADED=0, READY=0. READY=1 in the first cycle after release.
- Single load with ADDR=2, MATCH=8'hA5, OUT=8'h3C:
  - NEURON_RST=4'b0100 in cycle 1.
  - CONTROL in cycles 2..17 = 1010_0101_0011_1100.
  - DONE in cycle 18, LOADED=4'b0100.
  - With a real neuron attached, driving SEQ_IN with A5 (MSB first) yields SEQ_OUT = 3C.
- Broadcast with MATCH=8'hFF, OUT=8'h81: NEURON_RST=4'b1111 for one cycle, then 16 bits, LOADED=4'b1111.
- Out-of-range address (NUM_NEURONS=3, ADDR=3): NEURON_RST stays 0, DONE and ERR pulse together, LOADED unchanged.
- Back-to-back: CFG_VALID held high with two words → accepts at cycles 0 and 19, two DONE pulses (cycles 18 and 37). CFG_READY low throughout each transaction.
- Abort: RST asserted at the 5th SHIFT cycle → no DONE, LOADED=0, NEURON_RST all ones, and a new load completes normally afterwards.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron bank: loader FSM states and
// configuration-word sizing helpers used by both loader and neuron.
package neuron_pkg;

    typedef enum logic [1:0] {IDLE, ARM, SHIFT, FIN} state_e;

    localparam int DEF_MEMORY = 8;
    localparam int CFG_WORD_W = 2 * DEF_MEMORY;

    function automatic int cfg_word_w(input int memory);
        return 2 * memory;
    endfunction

    function automatic int cnt_w(input int memory);
        return (2 * memory > 1) ? $clog2(2 * memory) : 1;
    endfunction

endpackage

// File: rtl/cfg_serializer.sv
// Parallel-load, MSB-first PISO for one configuration word, with a bit
// counter that flags the final serial bit.
module cfg_serializer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] din,
    output logic             sout,
    output logic             last
);

    // Extra guard bit above the word keeps sout low until the first shift,
    // so sout can drive the neurons directly as a registered signal.
    logic [WIDTH:0]   sr;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sr  <= '0;
            cnt <= '0;
        end else if (load) begin
            sr  <= {1'b0, din};
            // Preset to -1: the priming shift in ARM wraps it to 0, so the
            // count equals the SHIFT-cycle index afterwards.
            cnt <= '1;
        end else if (shift_en) begin
            sr  <= {sr[WIDTH-1:0], 1'b0};
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign sout = sr[WIDTH];
    assign last = (cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/neuron_cfg_loader.sv
// Serial configuration master: resets the addressed neuron(s), then streams
// {MATCH, OUT} MSB-first on the shared CONTROL line.
module neuron_cfg_loader
    import neuron_pkg::*;
#(
    parameter int MEMORY      = 8,
    parameter int NUM_NEURONS = 4,
    parameter int ADDR_W      = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   CFG_VALID,
    output logic                   CFG_READY,
    input  logic [ADDR_W-1:0]      CFG_ADDR,
    input  logic                   CFG_BCAST,
    input  logic [MEMORY-1:0]      CFG_MATCH,
    input  logic [MEMORY-1:0]      CFG_OUT,
    output logic [NUM_NEURONS-1:0] NEURON_RST,
    output logic                   NEURON_CONTROL,
    output logic [NUM_NEURONS-1:0] LOADED,
    output logic                   DONE,
    output logic                   ERR
);

    localparam int WORD_W = cfg_word_w(MEMORY);
    localparam int CNT_W  = cnt_w(MEMORY);

    state_e                 state, state_nx;
    logic [NUM_NEURONS-1:0] mask_q;
    logic                   accept, shift_en, last;

    // An out-of-range address decodes to an empty mask.
    function automatic logic [NUM_NEURONS-1:0] sel_mask(input logic [ADDR_W-1:0] a,
                                                        input logic b);
        logic [NUM_NEURONS-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_NEURONS; i++)
            m[i] = b || (int'(a) == i);
        return m;
    endfunction

    assign CFG_READY = (state == IDLE) && !RST;
    assign accept    = CFG_READY && CFG_VALID;
    assign shift_en  = (state == ARM) || (state == SHIFT);

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = ARM;
            ARM:     state_nx = SHIFT;
            SHIFT:   if (last) state_nx = FIN;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NEURON_RST is loaded at the accept edge so the pulse lands in ARM.
    always_ff @(posedge CLK) begin
        if (RST) begin
            NEURON_RST <= '1;
            LOADED     <= '0;
            mask_q     <= '0;
        end else begin
            NEURON_RST <= accept ? sel_mask(CFG_ADDR, CFG_BCAST) : '0;
            if (accept)
                mask_q <= sel_mask(CFG_ADDR, CFG_BCAST);
            if (state == FIN)
                LOADED <= LOADED | mask_q;
        end
    end

    assign DONE = (state == FIN) && !RST;
    assign ERR  = DONE && (mask_q == '0);

    cfg_serializer #(
        .WIDTH (WORD_W),
        .CNT_W (CNT_W)
    ) u_ser (
        .CLK      (CLK),
        .RST      (RST),
        .load     (accept),
        .shift_en (shift_en),
        .din      ({CFG_MATCH, CFG_OUT}),
        .sout     (NEURON_CONTROL),
        .last     (last)
    );

endmodule

// File: tb/tb_neuron_cfg_loader.sv
// Bench for neuron_cfg_loader: two instances (4 and 3 neurons) share stimulus
// and are compared every cycle against a transaction-timeline model.
module tb_neuron_cfg_loader;

    localparam int MEM = 8;
    localparam int W   = 2 * MEM;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       valid = 1'b0, bcast = 1'b0;
    logic [1:0] addr = '0;
    logic [7:0] match = '0, outp = '0;

    logic       ready4, ctl4, done4, err4;
    logic [3:0] nrst4, ld4;
    logic       ready3, ctl3, done3, err3;
    logic [2:0] nrst3, ld3;

    neuron_cfg_loader #(.MEMORY(MEM), .NUM_NEURONS(4)) u4 (
        .CLK(CLK), .RST(RST), .CFG_VALID(valid), .CFG_READY(ready4),
        .CFG_ADDR(addr), .CFG_BCAST(bcast), .CFG_MATCH(match), .CFG_OUT(outp),
        .NEURON_RST(nrst4), .NEURON_CONTROL(ctl4), .LOADED(ld4),
        .DONE(done4), .ERR(err4)
    );

    neuron_cfg_loader #(.MEMORY(MEM), .NUM_NEURONS(3)) u3 (
        .CLK(CLK), .RST(RST), .CFG_VALID(valid), .CFG_READY(ready3),
        .CFG_ADDR(addr), .CFG_BCAST(bcast), .CFG_MATCH(match), .CFG_OUT(outp),
        .NEURON_RST(nrst3), .NEURON_CONTROL(ctl3), .LOADED(ld3),
        .DONE(done3), .ERR(err3)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] mask(input int n, input logic [1:0] a, input bit b);
        logic [3:0] m;
        m = '0;
        if (b) begin
            for (int i = 0; i < n; i++) m[i] = 1'b1;
        end else if (int'(a) < n) begin
            m[a] = 1'b1;
        end
        return m;
    endfunction

    // Model: a transaction is a fixed timeline measured from its accept edge.
    bit         chk_en = 0;
    bit         m_busy = 0, m_inrst = 0, m_bcast = 0;
    int         m_t = 0;
    logic [15:0] m_word = '0;
    logic [1:0] m_addr = '0;
    logic [3:0] m_ld4 = '0, m_ld3 = '0, tmp;

    always @(posedge CLK) begin
        if (RST) begin
            m_busy = 0; m_t = 0; m_inrst = 1; m_ld4 = '0; m_ld3 = '0;
        end else begin
            m_inrst = 0;
            if (m_busy) begin
                m_t++;
                if (m_t == W + 3) begin
                    m_busy = 0;
                    m_ld4 = m_ld4 | mask(4, m_addr, m_bcast);
                    m_ld3 = m_ld3 | mask(3, m_addr, m_bcast);
                end
            end else if (valid) begin
                m_busy = 1; m_t = 1;
                m_word = {match, outp}; m_addr = addr; m_bcast = bcast;
            end
        end
    end

    logic       e_ready, e_ctl, e_done;
    logic [3:0] mk4, mk3, e_nrst4, e_nrst3;

    always @(negedge CLK) begin
        if (chk_en) begin
            e_ready = !m_busy && !RST;
            e_ctl   = (m_busy && m_t >= 2 && m_t <= W + 1) ? m_word[W - 1 - (m_t - 2)] : 1'b0;
            e_done  = m_busy && (m_t == W + 2) && !RST;
            mk4     = mask(4, m_addr, m_bcast);
            mk3     = mask(3, m_addr, m_bcast);
            e_nrst4 = m_inrst ? 4'hF : (m_busy && m_t == 1) ? mk4 : 4'h0;
            e_nrst3 = m_inrst ? 4'h7 : (m_busy && m_t == 1) ? mk3 : 4'h0;
            chk("ready4", ready4, e_ready);
            chk("ready3", ready3, e_ready);
            chk("ctl4", ctl4, e_ctl);
            chk("ctl3", ctl3, e_ctl);
            chk("done4", done4, e_done);
            chk("done3", done3, e_done);
            chk("err4", err4, e_done && mk4 == 4'h0);
            chk("err3", err3, e_done && mk3 == 4'h0);
            chk("nrst4", nrst4, e_nrst4);
            chk("nrst3", {29'd0, nrst3}, e_nrst3);
            chk("loaded4", ld4, m_ld4);
            chk("loaded3", {29'd0, ld3}, m_ld3);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Call from an idle cycle after its negedge; returns at the negedge of cycle 19.
    task automatic do_load(input logic [1:0] a, input bit b, input logic [7:0] m,
                           input logic [7:0] o, output logic [3:0] r4,
                           output logic [2:0] r3, output logic [15:0] bits,
                           output logic d18, output logic e3);
        valid = 1'b1; addr = a; bcast = b; match = m; outp = o;
        tick();
        valid = 1'b0;
        @(negedge CLK);
        r4 = nrst4; r3 = nrst3;
        for (int k = 0; k < W; k++) begin
            @(negedge CLK);
            bits[W - 1 - k] = ctl4;
        end
        @(negedge CLK);
        d18 = done4; e3 = err3;
        @(negedge CLK);
    endtask

    logic [3:0]  r4;
    logic [2:0]  r3;
    logic [15:0] bits;
    logic        d18, e3;
    int          dpos[4];
    int          nd;

    initial begin
        // Reset held 3 cycles.
        tick();
        chk_en = 1;
        @(negedge CLK);
        chk("rst_nrst", nrst4, 4'hF);
        chk("rst_ctl", ctl4, 0);
        chk("rst_loaded", ld4, 0);
        chk("rst_ready", ready4, 0);
        tick(); tick();
        RST = 1'b0;
        @(negedge CLK);
        chk("ready_after_rst", ready4, 1);

        do_load(2'd2, 0, 8'hA5, 8'h3C, r4, r3, bits, d18, e3);
        chk("single_nrst", r4, 4'b0100);
        chk("single_bits", bits, 16'hA53C);
        chk("single_done", d18, 1);
        chk("single_loaded", ld4, 4'b0100);
        chk("single_ready", ready4, 1);

        do_load(2'd3, 0, 8'h5A, 8'hC3, r4, r3, bits, d18, e3);
        chk("oor_nrst3", r3, 3'b000);
        chk("oor_err3", e3, 1);
        chk("oor_done", d18, 1);
        chk("oor_loaded3", ld3, 3'b100);
        chk("oor_loaded4", ld4, 4'b1100);

        do_load(2'd0, 1, 8'hFF, 8'h81, r4, r3, bits, d18, e3);
        chk("bcast_nrst", r4, 4'hF);
        chk("bcast_bits", bits, 16'hFF81);
        chk("bcast_loaded4", ld4, 4'hF);
        chk("bcast_loaded3", ld3, 3'h7);

        // Back-to-back with CFG_VALID held high.
        nd = 0;
        valid = 1'b1; addr = 2'd1; bcast = 0; match = 8'h12; outp = 8'h34;
        for (int c = 1; c < 40; c++) begin
            tick();
            if (c == 1) begin addr = 2'd0; match = 8'h56; outp = 8'h78; end
            if (c == 20) valid = 1'b0;
            @(negedge CLK);
            if (done4 && nd < 4) begin dpos[nd] = c; nd++; end
            if (c == 19) chk("b2b_ready19", ready4, 1);
        end
        chk("b2b_ndone", nd, 2);
        chk("b2b_done0", dpos[0], 18);
        chk("b2b_done1", dpos[1], 37);

        // Abort at the 5th SHIFT cycle (cycle 6).
        valid = 1'b1; addr = 2'd1; bcast = 0; match = 8'hE7; outp = 8'h18;
        tick();
        valid = 1'b0;
        repeat (5) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        @(negedge CLK);
        chk("abort_nrst", nrst4, 4'hF);
        chk("abort_loaded", ld4, 0);
        chk("abort_done", done4, 0);
        do_load(2'd3, 0, 8'hC3, 8'h5A, r4, r3, bits, d18, e3);
        chk("post_abort_bits", bits, 16'hC35A);
        chk("post_abort_done", d18, 1);
        chk("post_abort_loaded", ld4, 4'b1000);

        // Randomized traffic, including requests while busy and stray resets.
        for (int i = 0; i < 1500; i++) begin
            tick();
            valid = ($urandom_range(0, 3) != 0);
            addr  = 2'($urandom_range(0, 3));
            bcast = ($urandom_range(0, 5) == 0);
            match = 8'($urandom);
            outp  = 8'($urandom);
            RST   = ($urandom_range(0, 99) == 0);
        end
        tick();
        RST = 1'b0; valid = 1'b0;
        repeat (25) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
